calc_controller: RTL
====================

CALC_CONTROLLER -- requirements
Module: calc_controller

Interface
REQ-001 SHALL have parameter WIDTH, default 10: operand, result and display width in bits.
REQ-002 SHALL have parameter MAX_VALUE, default 999: largest representable operand or result.
REQ-003 Clk  input  1: single clock; all logic on rising edge.
REQ-004 reset  input  1: synchronous, active-high.
REQ-005 key_valid  input  1: one-cycle pulse, key_code valid.
REQ-006 key_code  input  4: 0-9 digit, A add, B sub, C mul, D div, E equals, F clear.
REQ-007 display_value  output  WIDTH: binary value for the BCD/seven-segment path.
REQ-008 busy  output  1: computation in progress; keys other than F ignored.
REQ-009 error  output  1: sticky error indicator.
REQ-010 result_valid  output  1: one-cycle pulse when a new result is loaded.

Function
REQ-011 States SHALL be ENTER_A, OP_WAIT, ENTER_B, EXEC, DIV_RUN, RESULT, ERROR.
REQ-012 Digit in ENTER_A/ENTER_B SHALL set operand = operand*10 + digit; digit SHALL be ignored if result > MAX_VALUE.
REQ-013 Operator in ENTER_A or RESULT SHALL latch op and A (RESULT: A = result) and go to OP_WAIT with B = 0.
REQ-014 Operator in OP_WAIT SHALL replace latched op; operator in ENTER_B SHALL be ignored.
REQ-015 Digit in OP_WAIT SHALL go to ENTER_B with B = digit; digit in RESULT SHALL restart ENTER_A with A = digit, error cleared.
REQ-016 E in ENTER_B SHALL go to EXEC; E in any other state SHALL be ignored.
REQ-017 EXEC SHALL last one cycle for add/sub/mul, then RESULT; busy high during EXEC.
REQ-018 Add/mul SHALL compute at full width (mul 2*WIDTH); result > MAX_VALUE SHALL go to ERROR.
REQ-019 Sub with B > A SHALL go to ERROR; div with B = 0 SHALL go to ERROR without running the divider.
REQ-020 Div SHALL run a restoring divider: busy high exactly WIDTH+1 cycles from EXEC entry; quotient truncated; remainder discarded.
REQ-021 Entering RESULT SHALL pulse result_valid for one cycle, concurrent with the new display_value.
REQ-022 F in any state, including EXEC/DIV_RUN, SHALL abort, clear A, B, op, error, and go to ENTER_A next cycle.
REQ-023 display_value SHALL show A in ENTER_A/OP_WAIT/EXEC/DIV_RUN, B in ENTER_B, result in RESULT, 0 in ERROR.
REQ-024 Key effects SHALL be visible on outputs the cycle after key_valid is sampled.
REQ-025 In ERROR, only digits (restart as REQ-015) and F SHALL be accepted; error stays 1 until then.
REQ-026 key_valid while busy with non-F code SHALL be dropped, not queued.

Reset
REQ-027 reset SHALL force ENTER_A, A = B = 0, op = add, display_value = 0, busy = 0, error = 0, result_valid = 0.
REQ-028 reset SHALL take priority over key_valid in the same cycle and abort any division.

Configuration
REQ-029 Macro CALC_DIV_EN defined: key D selects division and the divider SHALL be instantiated.
REQ-030 CALC_DIV_EN undefined: key D SHALL be ignored in all states, DIV_RUN unreachable, no divider logic.

Structure
REQ-031 Shared package calc_pkg SHALL hold key-code constants, op encoding, state encoding and MAX_VALUE.
REQ-032 Division SHALL live in sub-module calc_divider (start/done handshake, WIDTH-iteration restoring).

Verification
REQ-033 Keys 1,2,A,3,4,E -> display 46, result_valid one pulse, error 0.
REQ-034 Keys 5,B,9,E -> ERROR, display 0, error 1; then key 7 -> display 7, error 0.
REQ-035 Keys 9,9,9,9 -> display 999 (fourth digit ignored); 3,0,C,4,0,E -> ERROR (1200 > 999).
REQ-036 CALC_DIV_EN: 1,0,0,D,7,E -> busy high 11 cycles, display 14; 5,D,0,E -> ERROR, busy never high beyond EXEC.
REQ-037 Key F during DIV_RUN cycle 4 -> next cycle busy 0, display 0, no result_valid pulse.
REQ-038 Chaining 7,A,8,E then A,1,E -> displays 15 then 16; reset asserted with key_valid -> all outputs 0.

Source files
------------

// File: rtl/calc_pkg.sv
// Shared constants for the calculator: key codes, operator and FSM state encodings, limits.
package calc_pkg;

  localparam int unsigned CALC_WIDTH     = 10;
  localparam int unsigned CALC_MAX_VALUE = 999;

  localparam logic [3:0] KEY_ADD = 4'hA;
  localparam logic [3:0] KEY_SUB = 4'hB;
  localparam logic [3:0] KEY_MUL = 4'hC;
  localparam logic [3:0] KEY_DIV = 4'hD;
  localparam logic [3:0] KEY_EQ  = 4'hE;
  localparam logic [3:0] KEY_CLR = 4'hF;

  typedef enum logic [1:0] {
    OP_ADD = 2'd0,
    OP_SUB = 2'd1,
    OP_MUL = 2'd2,
    OP_DIV = 2'd3
  } op_e;

  localparam logic [2:0] ST_ENTER_A = 3'd0;
  localparam logic [2:0] ST_OP_WAIT = 3'd1;
  localparam logic [2:0] ST_ENTER_B = 3'd2;
  localparam logic [2:0] ST_EXEC    = 3'd3;
  localparam logic [2:0] ST_DIV_RUN = 3'd4;
  localparam logic [2:0] ST_RESULT  = 3'd5;
  localparam logic [2:0] ST_ERROR   = 3'd6;

  function automatic logic is_digit(input logic [3:0] code);
    return code <= 4'd9;
  endfunction

  function automatic op_e key_to_op(input logic [3:0] code);
    op_e op;
    case (code)
      KEY_SUB: op = OP_SUB;
      KEY_MUL: op = OP_MUL;
      KEY_DIV: op = OP_DIV;
      default: op = OP_ADD;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/calc_if.sv
// Keypad-in / display-out bundle between the keypad driver and the calculator controller.
interface calc_if #(
  parameter int unsigned WIDTH = 10
);
  logic             key_valid;
  logic [3:0]       key_code;
  logic [WIDTH-1:0] display_value;
  logic             busy;
  logic             error;
  logic             result_valid;

  modport master (
    output key_valid, key_code,
    input  display_value, busy, error, result_valid
  );

  modport slave (
    input  key_valid, key_code,
    output display_value, busy, error, result_valid
  );
endinterface

// File: rtl/calc_divider.sv
// Restoring divider: one quotient bit per cycle, the first bit resolved on the start cycle,
// so done pulses WIDTH cycles after start. Remainder is kept internally only.
module calc_divider #(
  parameter int unsigned WIDTH = 10
) (
  input  logic             clk,
  input  logic             srst,
  input  logic             start_i,
  input  logic             abort_i,
  input  logic [WIDTH-1:0] dividend_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic [WIDTH-1:0] quotient_o,
  output logic             done_o
);
  localparam int unsigned CW = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quot_q, quot_d;
  logic [WIDTH-1:0] dsor_q, dsor_d;
  logic [CW-1:0]    count_q, count_d;
  logic             done_q, done_d;

  logic [WIDTH-1:0] rem_in, quot_in, dsor_in;
  logic [WIDTH-1:0] step_rem, step_quot;
  logic [WIDTH:0]   shifted, trial;

  // Single restoring step; on the start cycle it works straight from the operand inputs.
  always_comb begin
    rem_in    = start_i ? '0 : rem_q;
    quot_in   = start_i ? dividend_i : quot_q;
    dsor_in   = start_i ? divisor_i : dsor_q;
    shifted   = {rem_in, quot_in[WIDTH-1]};
    trial     = shifted - {1'b0, dsor_in};
    step_rem  = trial[WIDTH] ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
    step_quot = {quot_in[WIDTH-2:0], ~trial[WIDTH]};
  end

  always_comb begin
    rem_d   = rem_q;
    quot_d  = quot_q;
    dsor_d  = dsor_q;
    count_d = count_q;
    done_d  = 1'b0;
    if (abort_i) begin
      count_d = '0;
    end else if (start_i) begin
      rem_d   = step_rem;
      quot_d  = step_quot;
      dsor_d  = divisor_i;
      count_d = CW'(WIDTH - 1);
    end else if (count_q != '0) begin
      rem_d   = step_rem;
      quot_d  = step_quot;
      count_d = count_q - CW'(1);
      done_d  = (count_q == CW'(1));
    end
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      rem_q   <= '0;
      quot_q  <= '0;
      dsor_q  <= '0;
      count_q <= '0;
      done_q  <= 1'b0;
    end else begin
      rem_q   <= rem_d;
      quot_q  <= quot_d;
      dsor_q  <= dsor_d;
      count_q <= count_d;
      done_q  <= done_d;
    end
  end

  assign quotient_o = quot_q;
  assign done_o     = done_q;

endmodule

// File: rtl/calc_controller.sv
// Four-function keypad calculator FSM. Define CALC_DIV_EN to enable key D (division)
// and the calc_divider instance; otherwise key D is ignored and no divider is built.
module calc_controller
  import calc_pkg::*;
#(
  parameter int unsigned WIDTH     = CALC_WIDTH,
  parameter int unsigned MAX_VALUE = CALC_MAX_VALUE
) (
  input logic   Clk,
  input logic   reset,
  calc_if.slave bus
);
  localparam int unsigned SW = WIDTH + 1;
  localparam int unsigned PW = 2 * WIDTH;
  localparam int unsigned EW = WIDTH + 4;
  localparam logic [SW-1:0] MAX_SW = SW'(MAX_VALUE);
  localparam logic [PW-1:0] MAX_PW = PW'(MAX_VALUE);
  localparam logic [EW-1:0] MAX_EW = EW'(MAX_VALUE);

`ifdef CALC_DIV_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif

  logic [2:0]       state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] result_q, result_d;
  op_e              op_q, op_d;
  logic             result_valid_q, result_valid_d;

  logic [3:0]       code;
  logic             key_clr, key_dig, key_eq, key_op;
  op_e              key_opc;
  logic [WIDTH-1:0] digit_w;
  logic [EW-1:0]    a_acc, b_acc;
  logic             a_fits, b_fits;
  logic [SW-1:0]    sum;
  logic [PW-1:0]    prod;
  logic [WIDTH-1:0] disp;

  logic             div_start, div_abort, div_done;
  logic [WIDTH-1:0] div_quot;

  assign code    = bus.key_code;
  assign key_clr = bus.key_valid && (code == KEY_CLR);
  assign key_dig = bus.key_valid && is_digit(code);
  assign key_eq  = bus.key_valid && (code == KEY_EQ);
  assign key_op  = bus.key_valid &&
                   ((code == KEY_ADD) || (code == KEY_SUB) || (code == KEY_MUL) ||
                    (DIV_EN && (code == KEY_DIV)));
  assign key_opc = key_to_op(code);

  // Extra headroom so operand*10+digit never wraps before the range check.
  assign digit_w = {{(WIDTH-4){1'b0}}, code};
  assign a_acc   = ({4'b0000, a_q} * EW'(10)) + {{(EW-4){1'b0}}, code};
  assign b_acc   = ({4'b0000, b_q} * EW'(10)) + {{(EW-4){1'b0}}, code};
  assign a_fits  = (a_acc <= MAX_EW);
  assign b_fits  = (b_acc <= MAX_EW);

  assign sum  = {1'b0, a_q} + {1'b0, b_q};
  assign prod = {{WIDTH{1'b0}}, a_q} * {{WIDTH{1'b0}}, b_q};

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    op_d      = op_q;
    result_d  = result_q;
    div_start = 1'b0;
    div_abort = 1'b0;
    if (key_clr) begin
      state_d   = ST_ENTER_A;
      a_d       = '0;
      b_d       = '0;
      op_d      = OP_ADD;
      div_abort = 1'b1;
    end else begin
      case (state_q)
        ST_ENTER_A: begin
          if (key_dig) begin
            if (a_fits) a_d = a_acc[WIDTH-1:0];
          end else if (key_op) begin
            op_d    = key_opc;
            b_d     = '0;
            state_d = ST_OP_WAIT;
          end
        end
        ST_OP_WAIT: begin
          if (key_op) begin
            op_d = key_opc;
          end else if (key_dig) begin
            b_d     = digit_w;
            state_d = ST_ENTER_B;
          end
        end
        ST_ENTER_B: begin
          if (key_dig) begin
            if (b_fits) b_d = b_acc[WIDTH-1:0];
          end else if (key_eq) begin
            state_d = ST_EXEC;
          end
        end
        ST_EXEC: begin
          case (op_q)
            OP_ADD: begin
              if (sum > MAX_SW) state_d = ST_ERROR;
              else begin
                result_d = sum[WIDTH-1:0];
                state_d  = ST_RESULT;
              end
            end
            OP_SUB: begin
              if (b_q > a_q) state_d = ST_ERROR;
              else begin
                result_d = a_q - b_q;
                state_d  = ST_RESULT;
              end
            end
            OP_MUL: begin
              if (prod > MAX_PW) state_d = ST_ERROR;
              else begin
                result_d = prod[WIDTH-1:0];
                state_d  = ST_RESULT;
              end
            end
`ifdef CALC_DIV_EN
            OP_DIV: begin
              if (b_q == '0) state_d = ST_ERROR;
              else begin
                div_start = 1'b1;
                state_d   = ST_DIV_RUN;
              end
            end
`endif
            default: state_d = ST_ERROR;
          endcase
        end
        ST_DIV_RUN: begin
          if (div_done) begin
            result_d = div_quot;
            state_d  = ST_RESULT;
          end
        end
        ST_RESULT: begin
          if (key_op) begin
            a_d     = result_q;
            b_d     = '0;
            op_d    = key_opc;
            state_d = ST_OP_WAIT;
          end else if (key_dig) begin
            a_d     = digit_w;
            b_d     = '0;
            state_d = ST_ENTER_A;
          end
        end
        ST_ERROR: begin
          if (key_dig) begin
            a_d     = digit_w;
            b_d     = '0;
            state_d = ST_ENTER_A;
          end
        end
        default: state_d = ST_ENTER_A;
      endcase
    end
  end

  // result_valid marks the cycle a fresh result first appears on the display.
  assign result_valid_d = (state_d == ST_RESULT) && (state_q != ST_RESULT);

  always_ff @(posedge Clk) begin
    if (reset) begin
      state_q        <= ST_ENTER_A;
      a_q            <= '0;
      b_q            <= '0;
      result_q       <= '0;
      op_q           <= OP_ADD;
      result_valid_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      a_q            <= a_d;
      b_q            <= b_d;
      result_q       <= result_d;
      op_q           <= op_d;
      result_valid_q <= result_valid_d;
    end
  end

`ifdef CALC_DIV_EN
  calc_divider #(
    .WIDTH(WIDTH)
  ) u_divider (
    .clk       (Clk),
    .srst      (reset),
    .start_i   (div_start),
    .abort_i   (div_abort),
    .dividend_i(a_q),
    .divisor_i (b_q),
    .quotient_o(div_quot),
    .done_o    (div_done)
  );
`else
  logic unused_div;
  assign unused_div = div_start ^ div_abort;
  assign div_quot   = '0;
  assign div_done   = 1'b0;
`endif

  always_comb begin
    case (state_q)
      ST_ENTER_B: disp = b_q;
      ST_RESULT:  disp = result_q;
      ST_ERROR:   disp = '0;
      default:    disp = a_q;
    endcase
  end

  assign bus.display_value = disp;
  assign bus.busy          = (state_q == ST_EXEC) || (state_q == ST_DIV_RUN);
  assign bus.error         = (state_q == ST_ERROR);
  assign bus.result_valid  = result_valid_q;

endmodule
